pc_fetch: RTL

Fetch-side companion to the next-PC unit in the Harvard MIPS core. Owns the architectural PC register and drives the instruction-memory read handshake. Latches the fetched word and presents the current PC, PC+4 and the instruction to decode and next-PC logic. It then consumes the taken-redirect and next-PC result, applying MIPS branch-delay-slot ordering and halting the core on a fetch from address 0.

---
 rtl/pc_fetch_pkg.sv | 13 +
 rtl/pc_fetch.sv | 114 +++++++++++
 2 files changed

// File: rtl/pc_fetch_pkg.sv
// Core-wide fetch constants and the fetch FSM state type, shared with the next-PC unit.
package pc_fetch_pkg;

  localparam logic [31:0] FETCH_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] FETCH_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch.sv
// Architectural PC owner and instruction-memory fetch handshake, with MIPS delay-slot
// ordering of taken redirects and halt-on-fetch-from-HALT_ADDR.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = FETCH_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = FETCH_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic [31:0] instr_readdata,
  input  logic        instr_waitrequest,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] pc_next,
  output logic        active,
  output logic        addr_error
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instruction_q, instruction_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic         addr_error_q, addr_error_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  retire_pc;

  assign pc_plus4  = pc_q + 32'd4;
  // A pending target means the instruction now retiring is the delay slot.
  assign retire_pc = pend_valid_q ? pend_target_q : pc_plus4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    addr_error_d  = addr_error_q;

    if (clk_enable) begin
      case (state_q)
        FETCH: begin
          if (!instr_waitrequest) begin
            instruction_d = instr_readdata;
            state_d       = EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc_d = retire_pc;
            // A redirect raised by a delay-slot instruction is dropped.
            if (pend_valid_q) begin
              pend_valid_d = 1'b0;
            end else if (redirect) begin
              pend_valid_d  = 1'b1;
              pend_target_d = pc_next;
            end
            if (pend_valid_q && (retire_pc[1:0] != 2'b00)) begin
              addr_error_d = 1'b1;
              state_d      = HALTED;
            end else if (retire_pc == HALT_ADDR) begin
              state_d = HALTED;
            end else begin
              state_d = FETCH;
            end
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = HALTED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VECTOR;
      instruction_q <= 32'd0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
      addr_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      addr_error_q  <= addr_error_d;
    end
  end

  assign instr_address = pc_q;
  assign pc            = pc_q;
  assign pc4           = pc_plus4;
  assign instruction   = instruction_q;
  assign addr_error    = addr_error_q;
  assign instr_read    = (state_q == FETCH);
  assign instr_valid   = (state_q == EXEC);
  assign active        = (state_q != HALTED);

endmodule
